// File: rtl/gray_sweep_pkg.sv
// Shared types and helpers for the Gray-coded sweep scheduler.
// Optional early-termination feature is enabled with GRAY_SWEEP_ABORT_EN.
package gray_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GRAY_MAX_W = 32;

    // Address width for a sweep of `size` entries; never below 1 bit.
    function automatic int addr_w(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

    // Works for any width up to GRAY_MAX_W; callers size-cast in and out.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    always_comb begin
        int            sum;
        logic [PW-1:0] idx;
        gnt   = '0;
        valid = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = PW'(sum);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_sweep_sched.sv
// Round-robin owner of one Gray-coded address sweep engine shared by NREQ clients.
// Define GRAY_SWEEP_ABORT_EN to terminate a sweep when its owner drops req.
module gray_sweep_sched
    import gray_sweep_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int SIZE = 16,
    localparam int AW   = addr_w(SIZE),
    localparam int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            addr_valid,
    output logic [AW-1:0]   gray,
    output logic            last,
    output logic            done,
    output logic            abort
);

    state_t          state;
    logic [AW-1:0]   bin;
    logic [AW-1:0]   nb;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_valid;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (arb_gnt[i]) win = PW'(i);
    end

    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    assign nb      = bin + AW'(1);

`ifdef GRAY_SWEEP_ABORT_EN
    logic abort_q;
    logic owner_drop;
    assign owner_drop = ~|(req & grant);
    assign abort      = abort_q;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            bin        <= '0;
            gray       <= '0;
            grant      <= '0;
            ptr        <= '0;
            busy       <= 1'b0;
            addr_valid <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
`ifdef GRAY_SWEEP_ABORT_EN
            abort_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef GRAY_SWEEP_ABORT_EN
            abort_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state      <= RUN;
                        grant      <= arb_gnt;
                        ptr        <= ptr_nxt;
                        bin        <= '0;
                        gray       <= '0;
                        busy       <= 1'b1;
                        addr_valid <= 1'b1;
                        last       <= 1'b0;
                    end
                end
                RUN: begin
`ifdef GRAY_SWEEP_ABORT_EN
                    // Owner withdrawal beats both hold and the final address.
                    if (owner_drop) begin
                        state      <= IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        addr_valid <= 1'b0;
                        last       <= 1'b0;
                        abort_q    <= 1'b1;
                    end else
`endif
                    if (!hold) begin
                        if (last) begin
                            state      <= DONE;
                            grant      <= '0;
                            busy       <= 1'b0;
                            addr_valid <= 1'b0;
                            last       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            // gray follows the index on the same edge, never a cycle late.
                            bin  <= nb;
                            gray <= AW'(bin2gray(GRAY_MAX_W'(nb)));
                            last <= (nb == AW'(SIZE - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_sweep_sched.sv
// Bench for gray_sweep_sched: SIZE=16 and SIZE=6 instances against an integer model.
module tb_gray_sweep_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'd0;
    logic       hold = 1'b0;

    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b, valid_a, valid_b, last_a, last_b;
    logic       done_a, done_b, abort_a, abort_b;
    logic [3:0] gray_a;
    logic [2:0] gray_b;

    gray_sweep_sched #(.NREQ(4), .SIZE(16)) u_a (
        .clk(clk), .reset_n(reset_n), .req(req), .hold(hold),
        .grant(grant_a), .busy(busy_a), .addr_valid(valid_a), .gray(gray_a),
        .last(last_a), .done(done_a), .abort(abort_a)
    );

    gray_sweep_sched #(.NREQ(4), .SIZE(6)) u_b (
        .clk(clk), .reset_n(reset_n), .req(req), .hold(hold),
        .grant(grant_b), .busy(busy_b), .addr_valid(valid_b), .gray(gray_b),
        .last(last_b), .done(done_b), .abort(abort_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 idle, 1 sweeping, 2 done cycle; owner and index as plain ints.
    int sz[2]      = '{16, 6};
    int m_ph[2]    = '{0, 0};
    int m_own[2]   = '{0, 0};
    int m_idx[2]   = '{0, 0};
    int m_rr[2]    = '{0, 0};
    bit m_done[2]  = '{0, 0};
    bit m_abort[2] = '{0, 0};

    int seq16[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int seq6[6]   = '{0, 1, 3, 2, 6, 7};

    int cyc = 0, vcnt = 0, t_last = -100, t_done = -200;
    bit cap = 0, rec = 0;
    logic [31:0] q_a[$], q_b[$], gq[$];
    int gt[$];
    logic [3:0] gprev = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step(input int d);
        m_done[d]  = 1'b0;
        m_abort[d] = 1'b0;
        if (!reset_n) begin
            m_ph[d] = 0; m_idx[d] = 0; m_rr[d] = 0;
            return;
        end
        case (m_ph[d])
            0: begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m_rr[d] + k) % 4;
                    if (req[c]) begin
                        m_own[d] = c; m_rr[d] = (c + 1) % 4;
                        m_ph[d] = 1; m_idx[d] = 0;
                        break;
                    end
                end
            end
            1: begin
`ifdef GRAY_SWEEP_ABORT_EN
                if (!req[m_own[d]]) begin
                    m_ph[d] = 0; m_abort[d] = 1'b1;
                    return;
                end
`endif
                if (!hold) begin
                    if (m_idx[d] == sz[d] - 1) begin
                        m_ph[d] = 2; m_done[d] = 1'b1;
                    end else begin
                        m_idx[d]++;
                    end
                end
            end
            default: m_ph[d] = 0;
        endcase
    endfunction

    task automatic check_dut(input int d, input string nm, input logic [3:0] g, input logic b,
                             input logic v, input logic [31:0] gr, input logic l,
                             input logic dn, input logic ab);
        bit run;
        run = (m_ph[d] == 1);
        chk({nm, ".grant"}, 32'(g), run ? (32'd1 << m_own[d]) : 32'd0);
        chk({nm, ".busy"}, 32'(b), 32'(run));
        chk({nm, ".addr_valid"}, 32'(v), 32'(run));
        chk({nm, ".last"}, 32'(l), 32'(run && m_idx[d] == sz[d] - 1));
        chk({nm, ".done"}, 32'(dn), 32'(m_done[d]));
        chk({nm, ".abort"}, 32'(ab), 32'(m_abort[d]));
        if (run) chk({nm, ".gray"}, gr, 32'(m_idx[d] ^ (m_idx[d] >> 1)));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cyc++;
        check_dut(0, "a", grant_a, busy_a, valid_a, 32'(gray_a), last_a, done_a, abort_a);
        check_dut(1, "b", grant_b, busy_b, valid_b, 32'(gray_b), last_b, done_b, abort_b);
        if (valid_a) vcnt++;
        if (last_a) t_last = cyc;
        if (done_a) t_done = cyc;
        if (cap && valid_a && q_a.size() < 16) q_a.push_back(32'(gray_a));
        if (cap && valid_b && q_b.size() < 6) q_b.push_back(32'(gray_b));
        if (rec && grant_a != gprev && grant_a != 4'd0) begin
            gq.push_back(32'(grant_a));
            gt.push_back(cyc);
        end
        gprev = grant_a;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = 4'd0; hold = 1'b0;
        step(); step();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst.grant", 32'(grant_a), 0);
        chk("rst.gray", 32'(gray_a), 0);
        chk("rst.busy", 32'(busy_a), 0);

        // Plain sweep, requester 0, both sizes
        cap = 1; req = 4'b0001;
        for (int i = 0; i < 20; i++) step();
        cap = 0; req = 4'd0;
        chk("seq16.len", q_a.size(), 16);
        chk("seq6.len", q_b.size(), 6);
        for (int i = 0; i < 16; i++) chk("seq16", (i < q_a.size()) ? q_a[i] : 32'hdead, 32'(seq16[i]));
        for (int i = 0; i < 6; i++) chk("seq6", (i < q_b.size()) ? q_b[i] : 32'hdead, 32'(seq6[i]));
        chk("done_after_last", 32'(t_done - t_last), 1);
        step(); step();

        // Rotation with all requesters held high
        do_reset();
        rec = 1; gprev = 4'd0; req = 4'b1111;
        for (int i = 0; i < 80; i++) step();
        rec = 0; req = 4'd0;
        chk("rr.count", gq.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rr.grant", (i < gq.size()) ? gq[i] : 32'hdead, 32'd1 << (i % 4));
        for (int i = 1; i < 5; i++)
            chk("rr.period", (i < gt.size()) ? 32'(gt[i] - gt[i-1]) : 32'hdead, 18);

        // Hold at index 5 for 3 cycles and on the last address for 2
        do_reset();
        req = 4'b0001; vcnt = 0;
        for (int i = 0; i < 6; i++) step();
        chk("hold.at5", 32'(gray_a), 7);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("hold.frozen", 32'(gray_a), 7);
        hold = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("hold.last", 32'(last_a), 1);
        hold = 1'b1;
        step(); step();
        chk("hold.last_done", 32'(done_a), 0);
        hold = 1'b0;
        step();
        chk("hold.done", 32'(done_a), 1);
        chk("hold.vcnt", 32'(vcnt), 21);
        req = 4'd0;
        step();

        // Reset in the middle of a sweep owned by requester 1
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 10; i++) step();
        chk("mid.gray9", 32'(gray_a), 13);
        reset_n = 1'b0;
        step();
        chk("mid.zero", {grant_a, busy_a, valid_a, gray_a, last_a, done_a, abort_a}, 0);
        reset_n = 1'b1; req = 4'b1111;
        step();
        chk("mid.regrant0", 32'(grant_a), 1);

        // Owner drops req at index 4
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 5; i++) step();
        chk("drop.gray4", 32'(gray_a), 6);
        req = 4'b0010;
        step();
`ifdef GRAY_SWEEP_ABORT_EN
        chk("drop.abort", 32'(abort_a), 1);
        chk("drop.grant0", 32'(grant_a), 0);
        step();
        chk("drop.next", 32'(grant_a), 2);
`else
        chk("drop.keep", 32'(grant_a), 1);
        for (int i = 0; i < 30 && !done_a; i++) step();
        chk("drop.done", 32'(done_a), 1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            hold    = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_sweep_sched.md
# gray_sweep_sched

Round-robin scheduler that shares one Gray-coded address sweep engine between `NREQ` requesters. A granted requester receives one full sweep of `SIZE` Gray-coded addresses, from index 0 to `SIZE-1`, with per-cycle hold and end-of-sweep handshakes. It sits between the requesting clients and any Gray-indexed resource (pointer RAMs, LUT scans) that must be walked by one client at a time.

## Interface
- `NREQ`, default 4: number of requesters, range 2..16.
- `SIZE`, default 16: sweep length in addresses, SIZE ≥ 2; `AW = $clog2(SIZE)`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  **synchronous, active-low reset**.
- `req`  in  NREQ  per-requester sweep request, level.
- `hold`  in  1  stall; when high, the address does not advance.
- `grant`  out  NREQ  one-hot owner of the sweep; all zero when idle.
- `busy`  out  1  sweep in progress (state RUN).
- `addr_valid`  out  1  `gray` is a valid sweep address this cycle.
- `gray`  out  AW  current Gray-coded address.
- `last`  out  1  `gray` is the final address (index SIZE-1).
- `done`  out  1  one-cycle pulse after the final address completes.
- `abort`  out  1  one-cycle pulse when a sweep is terminated early. Constant 0 without the abort macro.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: when any `req` bit is high.
  - The round-robin winner is latched into `grant`.
  - Binary index and `gray` are cleared to 0.
- RUN:
  - `addr_valid = 1`, `busy = 1`.
  - If `hold = 0` and index < SIZE-1, the index increments.
  - If `hold = 1`, index and `gray` are frozen, and `addr_valid` stays high.
  - `last = (index == SIZE-1)`.
  - If `last = 1` and `hold = 0`, the next state is DONE.
- DONE:
  - Lasts one cycle. `done = 1`, `grant = 0`, `addr_valid = 0`.
  - Next state is IDLE unconditionally.
- Arithmetic:
  - `gray` is registered as `next_bin ^ (next_bin >> 1)` in the same edge as the binary index, so `gray` never lags the index.
  - Widths are AW throughout. No wrap to 0 occurs inside a sweep.
  - For non-power-of-two SIZE, the sweep ends at SIZE-1.
- Arbitration:
  - Round-robin. Priority starts at the index after the last granted requester.
  - After reset, requester 0 has highest priority.
  - The pointer updates only on IDLE → RUN.
  - Requests arriving while RUN or DONE are held off until IDLE.
- Simultaneous events:
  - `hold` high on the `last` cycle delays DONE until `hold` falls.
  - `req` of the owner may stay high through DONE. It is re-arbitrated in IDLE and loses to any other pending requester.
- Reset:
  - `reset_n = 0` in any state forces IDLE on the next edge. Any ongoing sweep is dropped without `done` or `abort`.
  - Reset values: `grant = 0`, `busy = 0`, `addr_valid = 0`, `gray = 0`, `last = 0`, `done = 0`, `abort = 0`.
  - The round-robin pointer resets to give requester 0 priority.

## Timing
- Latency:
  - `req` high at edge k (IDLE) → `grant`, `busy`, `addr_valid` and `gray = 0` visible after edge k.
  - First address advance at edge k+1 if `hold = 0`.
- Unstalled sweep:
  - SIZE cycles with `addr_valid`, then 1 DONE cycle, then 1 IDLE cycle.
  - Back-to-back grant period = SIZE + 2 cycles.
- All outputs are registered. No combinational path from `req` or `hold` to any output.

## Configuration
- Macro: `GRAY_SWEEP_ABORT_EN`.
- Defined:
  - If the owner's `req` bit is low during RUN at edge k, then after edge k: `abort = 1` for 1 cycle, `grant = 0`, `addr_valid = 0`, state IDLE.
  - No `done` pulse for that sweep.
  - Abort takes precedence over `last` and `hold` at the same edge.
- Undefined:
  - `req` is ignored after grant, and the sweep always completes.
  - `abort` is tied to 0.

## Structure
- Package `gray_sweep_pkg`:
  - State enum (IDLE, RUN, DONE).
  - `bin2gray` function parameterised on width.
  - Localparam helpers for AW.
- Sub-module `rr_arbiter`, parameter NREQ:
  - Inputs: `req`, pointer. Outputs: one-hot winner and valid.
  - Combinational. The pointer register stays in the scheduler.

## Test plan
- Reset, then `req = 4'b0001`, SIZE = 16, no hold:
  - `gray` sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
  - `last` with 8, `done` one cycle later, `grant` back to 0.
- `req = 4'b1111` held constantly:
  - Grants go 0001, 0010, 0100, 1000, 0001, with exactly SIZE + 2 cycles per grant period.
- `hold` pulsed for 3 cycles at index 5 and on the `last` cycle:
  - `gray` stays at 7 for 3 extra cycles, then continues.
  - DONE is delayed until `hold` falls.
  - Total valid cycles = SIZE + 3 + hold length at `last`.
- `reset_n` low at index 9 of a sweep:
  - After that edge, all outputs are 0 and no `done` or `abort` occurs.
  - The next grant goes to requester 0 if requested.
- With `GRAY_SWEEP_ABORT_EN` defined, owner drops `req` at index 4:
  - `abort` pulses, `grant` clears, no `done`, the next requester is granted after IDLE.
- Without the macro, the same stimulus runs the full sweep to `done`.
- SIZE = 6: sequence 0,1,3,2,6,7 with `last` on 7.
